// File: rtl/line_payload_packer_pkg.sv
// Shared definitions for the line payload packer: FSM encoding and header layout.
package line_payload_packer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPixHi,
        StPixLo,
        StDrop
    } state_e;

    localparam logic [7:0]  HDR_MAGIC_DEFAULT = 8'hA5;
    localparam int unsigned HDR_LEN           = 4;

    // Index of the final header byte, sized for the 2-bit header byte counter.
    localparam logic [1:0]  HDR_LAST_IDX      = 2'(HDR_LEN - 1);

endpackage

// File: rtl/line_payload_packer_sync_fifo_8b.sv
// Single-clock byte FIFO with registered read data and an exact occupancy count.
// Storage has DEPTH+1 locations; occupancy is capped at DEPTH.
module sync_fifo_8b #(
    parameter int unsigned DEPTH = 2047,
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic [CNT_W-1:0] count,
    output logic             wr_ok
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);

    logic [7:0]       mem_q [DEPTH+1];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             full, empty, rd_fire, wr_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A read from an empty FIFO is ignored entirely.
    assign rd_fire = rd_en & ~empty;
    // A read in the same cycle frees a slot, so a write at full still lands.
    assign wr_ok   = ~full | rd_fire;
    assign wr_fire = wr_en & wr_ok;

    assign rd_data = rd_data_q;
    assign count   = count_q;

    // Next-state for pointers, count and read register.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (wr_fire) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_fire) begin
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            rd_data_d = mem_q[rd_ptr_q];
        end
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/line_payload_packer.sv
// Packs camera lines into a byte FIFO: a 4-byte header per line followed by
// RGB565 pixels split high byte first. Lines that hit a full FIFO are truncated.
module line_payload_packer
    import line_payload_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2047,
    parameter logic [7:0]  HDR_MAGIC  = HDR_MAGIC_DEFAULT
) (
    input  logic        gmii_tx_clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    input  logic        fifo_rd_en,
    output logic [7:0]  fifo_data,
    output logic [10:0] fifo_data_count,
    output logic        overflow
);

    state_e      state_q, state_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        overflow_q, overflow_d;

    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_ok;

    assign overflow = overflow_q;

    // Byte storage.
    sync_fifo_8b #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (11)
    ) u_fifo (
        .clk     (gmii_tx_clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_data),
        .count   (fifo_data_count),
        .wr_ok   (wr_ok)
    );

    // FSM next-state, FIFO write request and pixel handshake.
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        frame_cnt_d = frame_cnt_q;
        line_cnt_d  = line_cnt_q;
        hold_d      = hold_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        pix_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (line_start) begin
                    state_d   = StHdr;
                    hdr_idx_d = '0;
                end
            end
            StHdr: begin
                // line_start is deliberately ignored until the header is complete.
                wr_en = 1'b1;
                case (hdr_idx_q)
                    2'd0:    wr_data = HDR_MAGIC;
                    2'd1:    wr_data = frame_cnt_q;
                    2'd2:    wr_data = line_cnt_q[15:8];
                    default: wr_data = line_cnt_q[7:0];
                endcase
                if (!wr_ok) begin
                    overflow_d = 1'b1;
                    state_d    = StDrop;
                end else if (hdr_idx_q == HDR_LAST_IDX) begin
                    state_d    = StPixHi;
                    line_cnt_d = line_cnt_q + 16'd1;
                end else begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                end
            end
            StPixHi: begin
                pix_ready = 1'b1;
                if (line_start) begin
                    state_d   = StHdr;
                    hdr_idx_d = '0;
                end else if (pix_valid) begin
                    wr_en   = 1'b1;
                    wr_data = pix_data[15:8];
                    hold_d  = pix_data[7:0];
                    if (!wr_ok) begin
                        overflow_d = 1'b1;
                        state_d    = StDrop;
                    end else begin
                        state_d = StPixLo;
                    end
                end
            end
            StPixLo: begin
                // A new line abandons the held low byte.
                if (line_start) begin
                    state_d   = StHdr;
                    hdr_idx_d = '0;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = hold_q;
                    if (!wr_ok) begin
                        overflow_d = 1'b1;
                        state_d    = StDrop;
                    end else begin
                        state_d = StPixHi;
                    end
                end
            end
            StDrop: begin
                pix_ready = 1'b1;
                if (line_start) begin
                    state_d   = StHdr;
                    hdr_idx_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Frame clear wins over any header-driven line increment, so a header
        // started together with frame_start carries line 0.
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            line_cnt_d  = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hdr_idx_q   <= '0;
            frame_cnt_q <= 8'h00;
            line_cnt_q  <= 16'h0000;
            hold_q      <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
            hold_q      <= hold_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_line_payload_packer.sv
// Scoreboard bench for line_payload_packer: expected FIFO bytes are queued as
// stimulus is driven and popped as bytes are read back.
module tb_line_payload_packer;

    localparam int unsigned DEPTH = 2047;

    logic        gmii_tx_clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        line_start;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data;
    logic [10:0] fifo_data_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb[$];
    int unsigned m_count;
    logic [7:0]  m_frame;
    logic [15:0] m_line;
    logic        m_drop;
    logic [7:0]  last_byte;

    line_payload_packer #(
        .FIFO_DEPTH (DEPTH),
        .HDR_MAGIC  (8'hA5)
    ) dut (
        .gmii_tx_clk     (gmii_tx_clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .line_start      (line_start),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_data       (fifo_data),
        .fifo_data_count (fifo_data_count),
        .overflow        (overflow)
    );

    always #4 gmii_tx_clk = ~gmii_tx_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    // Model of one attempted FIFO write (no same-cycle read).
    task automatic expect_write(input logic [7:0] b);
        if (m_drop) return;
        if (m_count < DEPTH) begin
            sb.push_back(b);
            m_count++;
        end else begin
            m_drop = 1'b1;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_count   = 0;
        m_frame   = 8'h00;
        m_line    = 16'h0000;
        m_drop    = 1'b0;
        last_byte = 8'h00;
    endtask

    task automatic do_reset();
        frame_start = 1'b0;
        line_start  = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = 16'h0000;
        fifo_rd_en  = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Pulses line_start (optionally with frame_start) and lets the header complete.
    task automatic start_line(input bit with_frame);
        if (with_frame) begin
            frame_start = 1'b1;
            m_frame     = m_frame + 8'd1;
            m_line      = 16'h0000;
        end
        line_start = 1'b1;
        tick();
        frame_start = 1'b0;
        line_start  = 1'b0;
        m_drop      = 1'b0;
        expect_write(8'hA5);
        expect_write(m_frame);
        expect_write(m_line[15:8]);
        expect_write(m_line[7:0]);
        m_line = m_line + 16'd1;
        repeat (4) tick();
    endtask

    // Presents one pixel and holds it until accepted; models only the high byte.
    task automatic send_pixel(input logic [15:0] d);
        int n = 0;
        while (pix_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (pix_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL pix_ready_timeout: pix_ready=%b required 1", pix_ready);
            return;
        end
        pix_valid = 1'b1;
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
        expect_write(d[15:8]);
    endtask

    task automatic drain();
        int n = 0;
        logic [7:0] exp_b;
        while (sb.size() > 0 && n < 4200) begin
            fifo_rd_en = 1'b1;
            tick();
            exp_b = sb.pop_front();
            m_count--;
            checks++;
            if (fifo_data !== exp_b) begin
                errors++;
                $display("FAIL drain_byte[%0d]: fifo_data=%h required %h", n, fifo_data, exp_b);
            end
            last_byte = exp_b;
            n++;
        end
        fifo_rd_en = 1'b0;
        checks++;
        if (fifo_data_count !== 11'(m_count)) begin
            errors++;
            $display("FAIL drain_count: count=%0d required %0d", fifo_data_count, m_count);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = 16'h0000;
        fifo_rd_en  = 1'b0;
        model_reset();
        #3;
        checks++;
        if (fifo_data_count !== 11'd0 || fifo_data !== 8'h00 || pix_ready !== 1'b0
            || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d data=%h ready=%b ovf=%b required 0 00 0 0",
                     fifo_data_count, fifo_data, pix_ready, overflow);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (fifo_data_count !== 11'd0 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_write: count=%0d ready=%b required 0 0",
                     fifo_data_count, pix_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] px[3] = '{16'h1234, 16'h5678, 16'h9ABC};
        start_line(1'b1);
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_hdr: pix_ready=%b required 1", pix_ready);
        end
        foreach (px[i]) begin
            send_pixel(px[i]);
            expect_write(px[i][7:0]);
        end
        tick();
        checks++;
        if (fifo_data_count !== 11'd10) begin
            errors++;
            $display("FAIL basic_peak_count: count=%0d required 10", fifo_data_count);
        end
        drain();
    endtask

    task automatic test_rd_empty();
        fifo_rd_en = 1'b1;
        tick();
        tick();
        fifo_rd_en = 1'b0;
        tick();
        checks++;
        if (fifo_data_count !== 11'd0 || fifo_data !== last_byte) begin
            errors++;
            $display("FAIL rd_empty: count=%0d data=%h required 0 %h",
                     fifo_data_count, fifo_data, last_byte);
        end
    endtask

    task automatic test_line_frame();
        start_line(1'b0);
        drain();
        start_line(1'b1);
        drain();
    endtask

    task automatic test_hdr_ignore();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        m_drop     = 1'b0;
        expect_write(8'hA5);
        expect_write(m_frame);
        expect_write(m_line[15:8]);
        expect_write(m_line[7:0]);
        m_line = m_line + 16'd1;
        tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (4) tick();
        checks++;
        if (fifo_data_count !== 11'd4 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL hdr_ignore: count=%0d ready=%b required 4 1",
                     fifo_data_count, pix_ready);
        end
        drain();
    endtask

    task automatic test_full();
        logic [7:0] hdr[4];
        logic [7:0] exp_b;
        start_line(1'b0);
        for (int i = 0; i < 1030; i++) begin
            send_pixel(16'(i * 3 + 16'h0107));
            expect_write(8'(i * 5 + 1));
            // the low byte of pixel i is i*3+7 truncated; keep model in sync
            if (!m_drop && sb.size() > 0) sb[sb.size() - 1] = 8'(i * 3 + 16'h0107);
        end
        tick();
        checks++;
        if (fifo_data_count !== 11'd2047 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_stop: count=%0d ovf=%b required 2047 1",
                     fifo_data_count, overflow);
        end
        checks++;
        if (fifo_data_count !== 11'(m_count)) begin
            errors++;
            $display("FAIL full_model_count: count=%0d required %0d", fifo_data_count, m_count);
        end
        // New line with reads running alongside the header writes.
        hdr = '{8'hA5, m_frame, m_line[15:8], m_line[7:0]};
        m_line = m_line + 16'd1;
        for (int k = 0; k < 5; k++) begin
            fifo_rd_en = 1'b1;
            line_start = (k == 0);
            tick();
            line_start = 1'b0;
            exp_b = sb.pop_front();
            m_count--;
            checks++;
            if (fifo_data !== exp_b) begin
                errors++;
                $display("FAIL resume_read[%0d]: fifo_data=%h required %h", k, fifo_data, exp_b);
            end
            if (k == 0) m_drop = 1'b0;
            else expect_write(hdr[k-1]);
        end
        fifo_rd_en = 1'b0;
        checks++;
        if (fifo_data_count !== 11'(m_count) || pix_ready !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL resume_state: count=%0d ready=%b ovf=%b required %0d 1 1",
                     fifo_data_count, pix_ready, overflow, m_count);
        end
        drain();
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_b;
        do_reset();
        start_line(1'b0);
        for (int i = 0; i < 1021; i++) begin
            send_pixel(16'(16'hC000 + i));
            expect_write(8'(i));
        end
        send_pixel(16'hBEEF);
        checks++;
        if (fifo_data_count !== 11'd2047) begin
            errors++;
            $display("FAIL full_rw_pre: count=%0d required 2047", fifo_data_count);
        end
        fifo_rd_en = 1'b1;
        tick();
        fifo_rd_en = 1'b0;
        exp_b = sb.pop_front();
        m_count--;
        expect_write(8'hEF);
        checks++;
        if (fifo_data_count !== 11'd2047 || overflow !== 1'b0 || fifo_data !== exp_b) begin
            errors++;
            $display("FAIL full_rw: count=%0d ovf=%b data=%h required 2047 0 %h",
                     fifo_data_count, overflow, fifo_data, exp_b);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b;
        start_line(1'b0);
        for (int i = 0; i < 248; i++) begin
            send_pixel(16'(16'h0A00 + i));
            expect_write(8'(i));
        end
        while (pix_ready !== 1'b1) tick();
        pix_valid  = 1'b1;
        pix_data   = 16'h7E81;
        fifo_rd_en = 1'b1;
        tick();
        pix_valid  = 1'b0;
        fifo_rd_en = 1'b0;
        exp_b = sb.pop_front();
        m_count--;
        expect_write(8'h7E);
        checks++;
        if (fifo_data_count !== 11'd500 || fifo_data !== exp_b) begin
            errors++;
            $display("FAIL pre_reset: count=%0d data=%h required 500 %h",
                     fifo_data_count, fifo_data, exp_b);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_data_count !== 11'd0 || fifo_data !== 8'h00 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d data=%h ready=%b required 0 00 0",
                     fifo_data_count, fifo_data, pix_ready);
        end
        model_reset();
        tick();
        rst_n     = 1'b1;
        pix_valid = 1'b1;
        repeat (10) tick();
        pix_valid = 1'b0;
        checks++;
        if (fifo_data_count !== 11'd0) begin
            errors++;
            $display("FAIL post_reset_idle: count=%0d required 0", fifo_data_count);
        end
        start_line(1'b0);
        checks++;
        if (fifo_data_count !== 11'd4) begin
            errors++;
            $display("FAIL post_reset_hdr: count=%0d required 4", fifo_data_count);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rd_empty();
        test_line_frame();
        test_hdr_ignore();
        test_full();
        test_full_rw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
